// File: rtl/ibex_rvfi_trace_buffer_pkg.sv
// Shared types for the RVFI trace capture buffer.
//   trace_mode_e  : capture policy latched on arm
//   trace_state_e : capture FSM encoding (also exported on state_o)
//   trace_rec_t   : compact per-instruction record, MSB->LSB as stored in the RAM
package ibex_rvfi_trace_buffer_pkg;

    typedef enum logic [1:0] {
        MODE_FREE = 2'd0,
        MODE_STOP = 2'd1,
        MODE_TRIG = 2'd2
    } trace_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_FROZEN  = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic        trap;
        logic        intr;
        logic [1:0]  mode;
        logic [4:0]  rd_addr;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] rd_wdata;
    } trace_rec_t;

    localparam int RecW = $bits(trace_rec_t);

    // The reserved encoding falls back to stop-on-full, the safest policy.
    function automatic trace_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd0:    return MODE_FREE;
            2'd2:    return MODE_TRIG;
            default: return MODE_STOP;
        endcase
    endfunction

endpackage

// File: rtl/ibex_trace_ram.sv
// Record storage for the trace buffer: Depth x Width flops, one synchronous
// write port and one asynchronous read port. Data is not reset; validity is
// tracked by the pointers/level in the parent.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write slot
//   wdata_i : record to store
//   raddr_i : read slot
//   rdata_o : record at raddr_i (combinational)
module ibex_trace_ram #(
    parameter int Depth = 16,
    parameter int Width = 105,
    localparam int PtrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PtrW-1:0]  waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [PtrW-1:0]  raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] r_mem [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) r_mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// Retired-instruction trace capture buffer. Taps the core's RVFI outputs,
// stores compact records in a circular buffer (free-run, stop-on-full or
// trigger+post-count modes) and drains them over a valid/ready read port.
//   clk_i/rst_ni        : clock, async active-low reset
//   arm_i               : flush, clear counters, latch config, start capture
//   cfg_mode_i/post_i   : capture mode and post-trigger record count
//   trig_*              : trigger on PC match and/or trapping record
//   rvfi_*              : retirement strobe and record fields
//   rd_valid_o/ready_i  : head record handshake; rd_data_o is the head record
//   level_o             : records held (0..Depth)
//   state_o             : FSM state
//   triggered_o         : trigger fired since arm
//   drop_cnt_o          : saturating count of lost records
module ibex_rvfi_trace_buffer
    import ibex_rvfi_trace_buffer_pkg::*;
#(
    parameter int Depth        = 16,
    parameter int DropCntWidth = 16,
    localparam int PtrW        = $clog2(Depth)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    arm_i,
    input  logic [1:0]              cfg_mode_i,
    input  logic [PtrW:0]           cfg_post_i,
    input  logic                    trig_pc_en_i,
    input  logic [31:0]             trig_pc_i,
    input  logic                    trig_trap_en_i,
    input  logic                    rvfi_valid,
    input  logic [31:0]             rvfi_pc_rdata,
    input  logic [31:0]             rvfi_insn,
    input  logic [31:0]             rvfi_rd_wdata,
    input  logic [4:0]              rvfi_rd_addr,
    input  logic                    rvfi_trap,
    input  logic                    rvfi_intr,
    input  logic [1:0]              rvfi_mode,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic [RecW-1:0]         rd_data_o,
    output logic [PtrW:0]           level_o,
    output logic [1:0]              state_o,
    output logic                    triggered_o,
    output logic [DropCntWidth-1:0] drop_cnt_o
);

    localparam logic [PtrW:0] LvlFull = (PtrW+1)'(Depth);

    trace_state_e            r_state;
    trace_mode_e             r_mode;
    logic [PtrW:0]           r_post_cfg;
    logic [PtrW:0]           r_post_cnt;
    logic [PtrW-1:0]         r_wptr;
    logic [PtrW-1:0]         r_rptr;
    logic [PtrW:0]           r_level;
    logic                    r_triggered;
    logic [DropCntWidth-1:0] r_drop;

    trace_rec_t      w_rec;
    logic [RecW-1:0] w_ram_rdata;
    logic            w_rd_valid, w_pop, w_active, w_full;
    logic            w_push_req, w_discard, w_we, w_overwrite, w_adv_r, w_drop;
    logic            w_trig_hit;

    assign w_rec = '{trap: rvfi_trap, intr: rvfi_intr, mode: rvfi_mode,
                     rd_addr: rvfi_rd_addr, pc: rvfi_pc_rdata, insn: rvfi_insn,
                     rd_wdata: rvfi_rd_wdata};

    assign w_rd_valid = (r_level != '0);
    assign w_pop      = w_rd_valid & rd_ready_i;
    assign w_active   = (r_state == ST_CAPTURE) | (r_state == ST_POST);
    assign w_full     = (r_level == LvlFull);

    // arm_i flushes, so a coincident retirement is simply dropped on the floor.
    assign w_push_req = rvfi_valid & w_active & ~arm_i;
    // Only a push into a full buffer with no pop to make room loses a record:
    // STOP loses the new one, every other mode loses the oldest.
    assign w_discard   = w_push_req & w_full & ~w_pop & (r_mode == MODE_STOP);
    assign w_we        = w_push_req & ~w_discard;
    assign w_overwrite = w_we & w_full & ~w_pop;
    assign w_adv_r     = w_pop | w_overwrite;
    assign w_drop      = w_discard | w_overwrite;

    assign w_trig_hit = w_we & (r_state == ST_CAPTURE) & (r_mode == MODE_TRIG) &
                        ((trig_pc_en_i & (rvfi_pc_rdata == trig_pc_i)) |
                         (trig_trap_en_i & rvfi_trap));

    ibex_trace_ram #(
        .Depth (Depth),
        .Width (RecW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (w_we),
        .waddr_i (r_wptr),
        .wdata_i (w_rec),
        .raddr_i (r_rptr),
        .rdata_o (w_ram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_FREE;
            r_post_cfg  <= '0;
            r_post_cnt  <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_triggered <= 1'b0;
            r_drop      <= '0;
        end else if (arm_i) begin
            r_state     <= ST_CAPTURE;
            r_mode      <= decode_mode(cfg_mode_i);
            r_post_cfg  <= cfg_post_i;
            r_post_cnt  <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_triggered <= 1'b0;
            r_drop      <= '0;
        end else begin
            if (w_we)    r_wptr <= r_wptr + 1'b1;
            if (w_adv_r) r_rptr <= r_rptr + 1'b1;

            if (w_we && !w_adv_r)      r_level <= r_level + 1'b1;
            else if (!w_we && w_pop)   r_level <= r_level - 1'b1;

            if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;

            case (r_state)
                ST_CAPTURE: begin
                    if (w_trig_hit) begin
                        r_triggered <= 1'b1;
                        r_post_cnt  <= r_post_cfg;
                        r_state     <= (r_post_cfg == '0) ? ST_FROZEN : ST_POST;
                    end
                end
                ST_POST: begin
                    if (w_we) begin
                        r_post_cnt <= r_post_cnt - 1'b1;
                        if (r_post_cnt == (PtrW+1)'(1)) r_state <= ST_FROZEN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_valid_o  = w_rd_valid;
    assign rd_data_o   = w_rd_valid ? w_ram_rdata : '0;
    assign level_o     = r_level;
    assign state_o     = r_state;
    assign triggered_o = r_triggered;
    assign drop_cnt_o  = r_drop;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
module tb_ibex_rvfi_trace_buffer;

    localparam int Depth = 16;
    localparam int PtrW  = 4;
    localparam int RecW  = 105;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             arm_i = 1'b0;
    logic [1:0]       cfg_mode_i = '0;
    logic [PtrW:0]    cfg_post_i = '0;
    logic             trig_pc_en_i = 1'b0;
    logic [31:0]      trig_pc_i = '0;
    logic             trig_trap_en_i = 1'b0;
    logic             rvfi_valid = 1'b0;
    logic [31:0]      rvfi_pc_rdata = '0;
    logic [31:0]      rvfi_insn = '0;
    logic [31:0]      rvfi_rd_wdata = '0;
    logic [4:0]       rvfi_rd_addr = '0;
    logic             rvfi_trap = 1'b0;
    logic             rvfi_intr = 1'b0;
    logic [1:0]       rvfi_mode = '0;
    logic             rd_valid_o;
    logic             rd_ready_i = 1'b0;
    logic [RecW-1:0]  rd_data_o;
    logic [PtrW:0]    level_o;
    logic [1:0]       state_o;
    logic             triggered_o;
    logic [15:0]      drop_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    ibex_rvfi_trace_buffer #(.Depth(Depth), .DropCntWidth(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .arm_i(arm_i), .cfg_mode_i(cfg_mode_i),
        .cfg_post_i(cfg_post_i), .trig_pc_en_i(trig_pc_en_i), .trig_pc_i(trig_pc_i),
        .trig_trap_en_i(trig_trap_en_i), .rvfi_valid(rvfi_valid),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr),
        .rvfi_mode(rvfi_mode), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .rd_data_o(rd_data_o), .level_o(level_o), .state_o(state_o),
        .triggered_o(triggered_o), .drop_cnt_o(drop_cnt_o)
    );

    // Inputs change 1ns after a rising edge; outputs are sampled there too.
    task automatic arm(input logic [1:0] mode, input logic [PtrW:0] post);
        arm_i = 1'b1; cfg_mode_i = mode; cfg_post_i = post;
        @(posedge clk_i); #1;
        arm_i = 1'b0;
    endtask

    task automatic set_rec(input logic [31:0] pc, input logic trap);
        rvfi_pc_rdata = pc; rvfi_trap = trap; rvfi_insn = 32'h0000_0013;
        rvfi_rd_wdata = ~pc; rvfi_rd_addr = pc[6:2]; rvfi_mode = 2'b11; rvfi_intr = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic trap);
        rvfi_valid = 1'b1; set_rec(pc, trap);
        @(posedge clk_i); #1;
        rvfi_valid = 1'b0;
    endtask

    task automatic pop;
        rd_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rd_ready_i = 1'b0;
    endtask

    task automatic test_reset;
        n_tests++;
        if ({state_o, level_o, rd_valid_o, triggered_o, drop_cnt_o} !== '0 || rd_data_o !== '0) begin
            n_fail++;
            $display("FAIL reset: state=%0d level=%0d valid=%0b trig=%0b drop=%0d data=%h required all 0",
                     state_o, level_o, rd_valid_o, triggered_o, drop_cnt_o, rd_data_o);
        end
    endtask

    task automatic test_free;
        arm(2'd0, '0);
        for (int n = 0; n < 20; n++) retire(32'h100 + 4*n, 1'b0);
        n_tests++;
        if (level_o !== 5'd16 || drop_cnt_o !== 16'd4 || state_o !== 2'd1 || triggered_o !== 1'b0) begin
            n_fail++;
            $display("FAIL free_status: level=%0d drop=%0d state=%0d trig=%0b required 16 4 1 0",
                     level_o, drop_cnt_o, state_o, triggered_o);
        end
        n_tests++;
        if (rd_valid_o !== 1'b1 || rd_data_o[95:64] !== 32'h110) begin
            n_fail++;
            $display("FAIL free_head: valid=%0b pc=%h required 1 00000110", rd_valid_o, rd_data_o[95:64]);
        end
    endtask

    task automatic test_stop;
        logic [RecW-1:0] exp_rec;
        int bad;
        arm(2'd1, '0);
        for (int n = 0; n < 20; n++) retire(32'h100 + 4*n, 1'b0);
        n_tests++;
        if (level_o !== 5'd16 || drop_cnt_o !== 16'd4) begin
            n_fail++;
            $display("FAIL stop_status: level=%0d drop=%0d required 16 4", level_o, drop_cnt_o);
        end
        exp_rec = {1'b0, 1'b0, 2'b11, 5'd0, 32'h100, 32'h13, ~32'h100};
        n_tests++;
        if (rd_data_o !== exp_rec) begin
            n_fail++;
            $display("FAIL stop_full_record: got %h required %h", rd_data_o, exp_rec);
        end
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (rd_valid_o !== 1'b1 || rd_data_o[95:64] !== 32'h100 + 4*k) bad++;
            pop();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stop_drain_order: %0d bad pops required 0", bad);
        end
        n_tests++;
        if (rd_valid_o !== 1'b0 || level_o !== 5'd0 || rd_data_o !== '0) begin
            n_fail++;
            $display("FAIL stop_empty: valid=%0b level=%0d data=%h required 0 0 0", rd_valid_o, level_o, rd_data_o);
        end
        // Pop on empty must be harmless.
        pop();
        n_tests++;
        if (level_o !== 5'd0 || rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_pop: level=%0d valid=%0b required 0 0", level_o, rd_valid_o);
        end
    endtask

    task automatic test_trig_pc;
        int bad;
        logic [31:0] last_pc;
        trig_pc_en_i = 1'b1; trig_pc_i = 32'h140;
        arm(2'd2, 5'd3);
        for (int n = 0; n < 40; n++) retire(32'h100 + 4*n, 1'b0);
        trig_pc_en_i = 1'b0;
        n_tests++;
        if (state_o !== 2'd3 || level_o !== 5'd16 || triggered_o !== 1'b1 || drop_cnt_o !== 16'd4) begin
            n_fail++;
            $display("FAIL trig_status: state=%0d level=%0d trig=%0b drop=%0d required 3 16 1 4",
                     state_o, level_o, triggered_o, drop_cnt_o);
        end
        bad = 0; last_pc = '0;
        for (int k = 0; k < 16; k++) begin
            if (rd_data_o[95:64] !== 32'h110 + 4*k) bad++;
            last_pc = rd_data_o[95:64];
            pop();
        end
        n_tests++;
        if (bad != 0 || last_pc !== 32'h14C) begin
            n_fail++;
            $display("FAIL trig_drain: bad=%0d last_pc=%h required 0 0000014c", bad, last_pc);
        end
        n_tests++;
        if (state_o !== 2'd3 || rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL frozen_after_drain: state=%0d valid=%0b required 3 0", state_o, rd_valid_o);
        end
    endtask

    task automatic test_trig_trap;
        int bad;
        trig_trap_en_i = 1'b1;
        arm(2'd2, 5'd0);
        for (int n = 0; n < 5; n++) retire(32'h300 + 4*n, n == 4);
        n_tests++;
        if (state_o !== 2'd3 || triggered_o !== 1'b1) begin
            n_fail++;
            $display("FAIL trap_frozen: state=%0d trig=%0b required 3 1", state_o, triggered_o);
        end
        for (int n = 5; n < 8; n++) retire(32'h300 + 4*n, 1'b0);
        trig_trap_en_i = 1'b0;
        n_tests++;
        if (level_o !== 5'd5 || drop_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL trap_level: level=%0d drop=%0d required 5 0", level_o, drop_cnt_o);
        end
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (rd_data_o[104] !== 1'b0 || rd_data_o[95:64] !== 32'h300 + 4*k) bad++;
            pop();
        end
        n_tests++;
        if (bad != 0 || rd_data_o[104] !== 1'b1 || rd_data_o[95:64] !== 32'h310) begin
            n_fail++;
            $display("FAIL trap_last_record: bad=%0d trap=%0b pc=%h required 0 1 00000310",
                     bad, rd_data_o[104], rd_data_o[95:64]);
        end
    endtask

    task automatic test_back_to_back;
        int bad;
        arm(2'd0, '0);
        for (int n = 0; n < 16; n++) retire(32'h200 + 4*n, 1'b0);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            if (rd_valid_o !== 1'b1 || rd_data_o[95:64] !== 32'h200 + 4*k) bad++;
            rvfi_valid = 1'b1; set_rec(32'h240 + 4*k, 1'b0); rd_ready_i = 1'b1;
            @(posedge clk_i); #1;
            rvfi_valid = 1'b0; rd_ready_i = 1'b0;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b_order: %0d bad pops required 0", bad);
        end
        n_tests++;
        if (level_o !== 5'd16 || drop_cnt_o !== 16'd0 || rd_data_o[95:64] !== 32'h280) begin
            n_fail++;
            $display("FAIL b2b_status: level=%0d drop=%0d head=%h required 16 0 00000280",
                     level_o, drop_cnt_o, rd_data_o[95:64]);
        end
    endtask

    task automatic test_rearm;
        arm(2'd0, '0);
        for (int n = 0; n < 18; n++) retire(32'h400 + 4*n, 1'b0);
        arm_i = 1'b1; cfg_mode_i = 2'd0; rvfi_valid = 1'b1; set_rec(32'h500, 1'b0);
        @(posedge clk_i); #1;
        arm_i = 1'b0; rvfi_valid = 1'b0;
        n_tests++;
        if (level_o !== 5'd0 || drop_cnt_o !== 16'd0 || state_o !== 2'd1 || rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm: level=%0d drop=%0d state=%0d valid=%0b required 0 0 1 0",
                     level_o, drop_cnt_o, state_o, rd_valid_o);
        end
    endtask

    task automatic test_async_reset;
        trig_trap_en_i = 1'b1;
        arm(2'd2, 5'd2);
        retire(32'h600, 1'b1);
        for (int n = 1; n < 20; n++) retire(32'h600 + 4*n, 1'b0);
        trig_trap_en_i = 1'b0;
        arm(2'd0, '0);
        for (int n = 0; n < 18; n++) retire(32'h700 + 4*n, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        n_tests++;
        if ({state_o, level_o, rd_valid_o, triggered_o, drop_cnt_o} !== '0 || rd_data_o !== '0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d level=%0d valid=%0b trig=%0b drop=%0d required all 0",
                     state_o, level_o, rd_valid_o, triggered_o, drop_cnt_o);
        end
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;
        retire(32'h800, 1'b0);
        n_tests++;
        if (state_o !== 2'd0 || level_o !== 5'd0) begin
            n_fail++;
            $display("FAIL idle_ignores: state=%0d level=%0d required 0 0", state_o, level_o);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        test_reset();
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;
        test_free();
        test_stop();
        test_trig_pc();
        test_trig_trap();
        test_back_to_back();
        test_rearm();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
